// File: rtl/array_sort_check_engine.sv
// Streams an array from a variable-latency read port and reports whether it is sorted, plus the first inversion index.
// Optional macro SORT_CHECK_COUNT_EN: scan the whole array and count every inversion on inv_count.
module array_sort_check_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int SIGNED_CMP = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  descending,
  input  logic                  strict,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  sorted,
`ifdef SORT_CHECK_COUNT_EN
  output logic [ADDR_WIDTH:0]   inv_count,
`endif
  output logic [ADDR_WIDTH-1:0] inv_index
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARMED, S_FETCH0, S_WAIT0, S_CHECK_END,
    S_FETCH, S_WAIT, S_COMPARE, S_DONE_SORTED, S_DONE_UNSORTED
  } state_t;

  localparam logic [ADDR_WIDTH:0] ONE = 1;
  localparam logic [ADDR_WIDTH:0] TWO = 2;

  // Reset asserts immediately but releases only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t                state, state_nxt;
  logic                  desc_q, strict_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q, idx;
  logic [DATA_WIDTH-1:0] prev, cur;
  logic                  gt, lt, eq, inversion, arm;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    if (SIGNED_CMP != 0) begin
      gt = $signed(prev) > $signed(cur);
      lt = $signed(prev) < $signed(cur);
    end else begin
      gt = prev > cur;
      lt = prev < cur;
    end
  end

  assign eq        = (prev == cur);
  assign inversion = (desc_q ? lt : gt) | (strict_q & eq);
  assign arm       = go & ((state == S_IDLE) | (state == S_DONE_SORTED) | (state == S_DONE_UNSORTED));

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    sorted    = 1'b0;
    case (state)
      S_IDLE: if (go) state_nxt = S_ARMED;
      S_ARMED: begin
        busy = 1'b1;
        if (!go) state_nxt = (len_q < TWO) ? S_DONE_SORTED : S_FETCH0;
      end
      S_FETCH0: begin
        busy      = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = base_q;
        state_nxt = S_WAIT0;
      end
      S_WAIT0: begin
        busy = 1'b1;
        if (mem_valid) state_nxt = S_CHECK_END;
      end
      S_CHECK_END: begin
        busy = 1'b1;
        if (idx == len_q) begin
`ifdef SORT_CHECK_COUNT_EN
          state_nxt = (inv_count != '0) ? S_DONE_UNSORTED : S_DONE_SORTED;
`else
          state_nxt = S_DONE_SORTED;
`endif
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        busy      = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = base_q + idx[ADDR_WIDTH-1:0];  // wraps at the top of memory
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (mem_valid) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        busy = 1'b1;
`ifdef SORT_CHECK_COUNT_EN
        state_nxt = S_CHECK_END;
`else
        state_nxt = inversion ? S_DONE_UNSORTED : S_CHECK_END;
`endif
      end
      S_DONE_SORTED: begin
        done   = 1'b1;
        sorted = 1'b1;
        if (go) state_nxt = S_ARMED;
      end
      S_DONE_UNSORTED: begin
        done = 1'b1;
        if (go) state_nxt = S_ARMED;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      desc_q    <= 1'b0;
      strict_q  <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
      prev      <= '0;
      cur       <= '0;
      inv_index <= '0;
`ifdef SORT_CHECK_COUNT_EN
      inv_count <= '0;
`endif
    end else begin
      if (arm) begin
        desc_q    <= descending;
        strict_q  <= strict;
        base_q    <= base_addr;
        len_q     <= length;
        idx       <= '0;
        inv_index <= '0;
`ifdef SORT_CHECK_COUNT_EN
        inv_count <= '0;
`endif
      end
      case (state)
        S_WAIT0: if (mem_valid) begin
          prev <= mem_rdata;
          idx  <= ONE;
        end
        S_WAIT: if (mem_valid) cur <= mem_rdata;
        S_COMPARE: begin
`ifdef SORT_CHECK_COUNT_EN
          if (inversion) begin
            if (inv_count == '0) inv_index <= idx[ADDR_WIDTH-1:0];
            inv_count <= inv_count + ONE;
          end
          prev <= cur;
          idx  <= idx + ONE;
`else
          if (inversion) begin
            inv_index <= idx[ADDR_WIDTH-1:0];
          end else begin
            prev <= cur;
            idx  <= idx + ONE;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_array_sort_check_engine.sv
// Bench for array_sort_check_engine: unsigned and signed instances share stimulus, each with its own latency-modelled memory port.
module tb_array_sort_check_engine;

  localparam int AW = 10;
  localparam int DW = 32;
`ifdef SORT_CHECK_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, go, descending, strict;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          mem_rd [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_rdata [2] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5};
  logic          mem_valid [2] = '{1'b0, 1'b0};
  logic          busy [2], done [2], sorted [2];
  logic [AW-1:0] inv_index [2];
`ifdef SORT_CHECK_COUNT_EN
  logic [AW:0]   inv_count [2];
`endif

  always #5 clock = ~clock;

  array_sort_check_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIGNED_CMP(0)) dut_u (
    .clock(clock), .reset(reset), .go(go), .descending(descending), .strict(strict),
    .base_addr(base_addr), .length(length), .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]),
    .mem_rdata(mem_rdata[0]), .mem_valid(mem_valid[0]), .busy(busy[0]), .done(done[0]),
    .sorted(sorted[0]),
`ifdef SORT_CHECK_COUNT_EN
    .inv_count(inv_count[0]),
`endif
    .inv_index(inv_index[0]));

  array_sort_check_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIGNED_CMP(1)) dut_s (
    .clock(clock), .reset(reset), .go(go), .descending(descending), .strict(strict),
    .base_addr(base_addr), .length(length), .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]),
    .mem_rdata(mem_rdata[1]), .mem_valid(mem_valid[1]), .busy(busy[1]), .done(done[1]),
    .sorted(sorted[1]),
`ifdef SORT_CHECK_COUNT_EN
    .inv_count(inv_count[1]),
`endif
    .inv_index(inv_index[1]));

  typedef struct { logic srt; logic [AW-1:0] idx; int nreads; } exp_t;
  exp_t sb0[$], sb1[$];
  int n_vec = 0, n_err = 0;

  logic [DW-1:0] mem [1024];
  int            lat = 1;
  bit            spur_en = 1'b0;
  int            cnt [2];
  bit            pend [2] = '{1'b0, 1'b0};
  bit            echo [2] = '{1'b0, 1'b0};
  logic [AW-1:0] paddr [2];
  int            rd_count [2] = '{0, 0};
  logic [AW-1:0] addr_log[$];

  logic          obs_sorted [2];
  logic [AW-1:0] obs_idx [2];
  int            obs_reads [2];
  int            rd_base [2];
  int            log_base;
  logic          hold_busy, hold_done;
  int            hold_reads;

  // Memory responder: data arrives `lat` cycles after the request; spur_en adds a bogus extra valid.
  always @(negedge clock) begin
    for (int g = 0; g < 2; g++) begin
      mem_valid[g] = 1'b0;
      mem_rdata[g] = 32'hA5A5_A5A5;
      if (echo[g]) begin
        mem_valid[g] = 1'b1;
        mem_rdata[g] = '0;
        echo[g] = 1'b0;
      end else if (pend[g]) begin
        cnt[g]--;
        if (cnt[g] <= 0) begin
          mem_valid[g] = 1'b1;
          mem_rdata[g] = mem[paddr[g]];
          pend[g] = 1'b0;
          echo[g] = spur_en;
        end
      end
      if (mem_rd[g] === 1'b1) begin
        pend[g] = 1'b1;
        cnt[g] = lat;
        paddr[g] = mem_addr[g];
        rd_count[g]++;
        if (g == 0) addr_log.push_back(mem_addr[g]);
      end
    end
  end

  function automatic exp_t model(input logic [AW-1:0] b, input int n, input bit d, input bit s, input bit sg);
    exp_t e;
    e.srt = 1'b1;
    e.idx = '0;
    e.nreads = (n < 2) ? 0 : n;
    for (int i = 1; i < n; i++) begin
      logic [DW-1:0] a = mem[AW'(b + AW'(i - 1))];
      logic [DW-1:0] c = mem[AW'(b + AW'(i))];
      bit lt_v = sg ? ($signed(a) < $signed(c)) : (a < c);
      bit gt_v = sg ? ($signed(a) > $signed(c)) : (a > c);
      if ((d ? lt_v : gt_v) || (s && a == c)) begin
        if (e.srt) begin
          e.idx = AW'(i);
          if (!COUNT_EN) e.nreads = i + 1;
        end
        e.srt = 1'b0;
        if (!COUNT_EN) break;
      end
    end
    return e;
  endfunction

  task automatic run_scan(input bit d, input bit s, input logic [AW-1:0] b, input logic [AW:0] n,
                          input int hold, input bit scramble);
    bit timed_out = 1'b1;
    @(negedge clock);
    descending = d; strict = s; base_addr = b; length = n; go = 1'b1;
    rd_base[0] = rd_count[0];
    rd_base[1] = rd_count[1];
    log_base = addr_log.size();
    repeat (hold) @(negedge clock);
    hold_busy = busy[0];
    hold_done = done[0];
    hold_reads = rd_count[0] - rd_base[0];
    go = 1'b0;
    if (scramble) begin
      descending = ~d; strict = ~s; base_addr = ~b; length = 11'd1;
    end
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (done[0] === 1'b1 && done[1] === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (timed_out) begin
      n_vec++; n_err++;
      $display("FAIL scan_timeout: done=%b/%b after 3000 cycles, required 1/1", done[0], done[1]);
    end
    for (int g = 0; g < 2; g++) begin
      obs_sorted[g] = sorted[g];
      obs_idx[g] = inv_index[g];
      obs_reads[g] = rd_count[g] - rd_base[g];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; go = 1'b0; descending = 1'b0; strict = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(negedge clock);
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if ({mem_rd[g], busy[g], done[g], sorted[g]} !== 4'b0 || mem_addr[g] !== '0 || inv_index[g] !== '0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: rd/busy/done/sorted=%b%b%b%b addr=%0d idx=%0d, required all 0",
                 g, mem_rd[g], busy[g], done[g], sorted[g], mem_addr[g], inv_index[g]);
      end
    end
    reset = 1'b1;
    repeat (4) @(negedge clock);
    n_vec++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || rd_count[0] != 0) begin
      n_err++;
      $display("FAIL idle_after_release: busy=%b done=%b reads=%0d, required 0/0/0", busy[0], done[0], rd_count[0]);
    end
  endtask

  task automatic test_order_modes();
    logic [DW-1:0] cd [5][5] = '{
      '{32'd1, 32'd2, 32'd2, 32'd7, 32'd9},
      '{32'd1, 32'd2, 32'd2, 32'd7, 32'd9},
      '{32'd5, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFF8},
      '{32'd5, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFF8},
      '{32'd9, 32'd7, 32'd7, 32'd2, 32'd1}};
    bit cdesc [5] = '{0, 0, 1, 1, 0};
    bit cstr  [5] = '{0, 1, 0, 1, 0};
    bit su [5] = '{1, 0, 0, 0, 0};  int iu [5] = '{0, 2, 2, 2, 1};  int ru [5] = '{5, 3, 3, 3, 2};
    bit ss [5] = '{1, 0, 1, 0, 0};  int is [5] = '{0, 2, 0, 3, 1};  int rs [5] = '{5, 3, 5, 4, 2};
    exp_t e0, e1;
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) mem[100 + j] = cd[i][j];
      sb0.push_back('{su[i], AW'(iu[i]), COUNT_EN ? 5 : ru[i]});
      sb1.push_back('{ss[i], AW'(is[i]), COUNT_EN ? 5 : rs[i]});
      run_scan(cdesc[i], cstr[i], 10'd100, 11'd5, 2, 1'b0);
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      n_vec++;
      if (obs_sorted[0] !== e0.srt || obs_idx[0] !== e0.idx || obs_reads[0] != e0.nreads) begin
        n_err++;
        $display("FAIL order_case%0d unsigned: sorted=%b idx=%0d reads=%0d, expected %b/%0d/%0d",
                 i, obs_sorted[0], obs_idx[0], obs_reads[0], e0.srt, e0.idx, e0.nreads);
      end
      n_vec++;
      if (obs_sorted[1] !== e1.srt || obs_idx[1] !== e1.idx || obs_reads[1] != e1.nreads) begin
        n_err++;
        $display("FAIL order_case%0d signed: sorted=%b idx=%0d reads=%0d, expected %b/%0d/%0d",
                 i, obs_sorted[1], obs_idx[1], obs_reads[1], e1.srt, e1.idx, e1.nreads);
      end
      if (i == 0) begin
        bit bad = (addr_log.size() - log_base) != 5;
        for (int j = 0; j < 5 && !bad; j++) if (addr_log[log_base + j] !== AW'(100 + j)) bad = 1'b1;
        n_vec++;
        if (bad) begin
          n_err++;
          $display("FAIL addr_sequence: %0d reads starting at %0d, required 5 reads at 100..104",
                   addr_log.size() - log_base, addr_log[log_base]);
        end
      end
    end
  endtask

  task automatic test_short_and_hold();
    exp_t e0, e1;
    for (int n = 0; n < 2; n++) begin
      sb0.push_back('{1'b1, '0, 0});
      sb1.push_back('{1'b1, '0, 0});
      run_scan(1'b0, 1'b1, 10'd50, 11'(n), 4, 1'b0);
      n_vec++;
      if (hold_busy !== 1'b1 || hold_done !== 1'b0 || hold_reads != 0) begin
        n_err++;
        $display("FAIL armed_hold len%0d: busy=%b done=%b reads=%0d, required 1/0/0", n, hold_busy, hold_done, hold_reads);
      end
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      n_vec++;
      if (obs_sorted[0] !== e0.srt || obs_sorted[1] !== e1.srt || obs_reads[0] != e0.nreads || obs_idx[0] !== e0.idx) begin
        n_err++;
        $display("FAIL short_len%0d: sorted=%b/%b reads=%0d idx=%0d, expected %b/%b/%0d/%0d",
                 n, obs_sorted[0], obs_sorted[1], obs_reads[0], obs_idx[0], e0.srt, e1.srt, e0.nreads, e0.idx);
      end
    end
  endtask

  task automatic test_wrap_latency();
    int lats [3] = '{1, 3, 7};
    logic [AW-1:0] want [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    exp_t e0;
    mem[1022] = 32'd10; mem[1023] = 32'd20; mem[0] = 32'd30; mem[1] = 32'd40;
    spur_en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      bit bad;
      lat = lats[t];
      sb0.push_back('{1'b1, '0, 4});
      run_scan(1'b0, 1'b1, 10'd1022, 11'd4, 2, 1'b0);
      e0 = sb0.pop_front();
      n_vec++;
      if (obs_sorted[0] !== e0.srt || obs_idx[0] !== e0.idx || obs_reads[0] != e0.nreads) begin
        n_err++;
        $display("FAIL wrap_lat%0d: sorted=%b idx=%0d reads=%0d, expected %b/%0d/%0d",
                 lat, obs_sorted[0], obs_idx[0], obs_reads[0], e0.srt, e0.idx, e0.nreads);
      end
      bad = (addr_log.size() - log_base) != 4;
      for (int j = 0; j < 4 && !bad; j++) if (addr_log[log_base + j] !== want[j]) bad = 1'b1;
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL wrap_addr_lat%0d: %0d reads, third address %0d, required 1022,1023,0,1",
                 lat, addr_log.size() - log_base, addr_log[log_base + 2]);
      end
    end
    spur_en = 1'b0;
    lat = 1;
  endtask

  task automatic test_back_to_back();
    exp_t e0;
    for (int j = 0; j < 5; j++) mem[200 + j] = DW'(j == 0 ? 1 : j == 1 ? 2 : j == 2 ? 2 : j == 3 ? 7 : 9);
    sb0.push_back('{1'b0, 10'd2, COUNT_EN ? 5 : 3});
    run_scan(1'b0, 1'b1, 10'd200, 11'd5, 1, 1'b1);
    e0 = sb0.pop_front();
    n_vec++;
    if (obs_sorted[0] !== e0.srt || obs_idx[0] !== e0.idx || obs_reads[0] != e0.nreads) begin
      n_err++;
      $display("FAIL inputs_after_arm: sorted=%b idx=%0d reads=%0d, expected %b/%0d/%0d",
               obs_sorted[0], obs_idx[0], obs_reads[0], e0.srt, e0.idx, e0.nreads);
    end
    sb0.push_back('{1'b0, 10'd1, COUNT_EN ? 5 : 2});
    run_scan(1'b1, 1'b0, 10'd200, 11'd5, 1, 1'b0);
    e0 = sb0.pop_front();
    n_vec++;
    if (obs_sorted[0] !== e0.srt || obs_idx[0] !== e0.idx || obs_reads[0] != e0.nreads) begin
      n_err++;
      $display("FAIL restart_from_done: sorted=%b idx=%0d reads=%0d, expected %b/%0d/%0d",
               obs_sorted[0], obs_idx[0], obs_reads[0], e0.srt, e0.idx, e0.nreads);
    end
  endtask

  task automatic test_random();
    exp_t e0, e1;
    for (int it = 0; it < 8; it++) begin
      int n = $urandom_range(0, 8);
      logic [AW-1:0] b = AW'($urandom_range(0, 1023));
      bit d = 1'($urandom_range(0, 1));
      bit s = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        int v = -3 + j + (($urandom_range(0, 5) == 0) ? -2 : 0);
        mem[AW'(b + AW'(j))] = DW'(d ? -v : v);
      end
      sb0.push_back(model(b, n, d, s, 1'b0));
      sb1.push_back(model(b, n, d, s, 1'b1));
      run_scan(d, s, b, 11'(n), 2, 1'b0);
      e0 = sb0.pop_front();
      e1 = sb1.pop_front();
      n_vec++;
      if (obs_sorted[0] !== e0.srt || obs_idx[0] !== e0.idx || obs_reads[0] != e0.nreads) begin
        n_err++;
        $display("FAIL random%0d unsigned: sorted=%b idx=%0d reads=%0d, expected %b/%0d/%0d",
                 it, obs_sorted[0], obs_idx[0], obs_reads[0], e0.srt, e0.idx, e0.nreads);
      end
      n_vec++;
      if (obs_sorted[1] !== e1.srt || obs_idx[1] !== e1.idx || obs_reads[1] != e1.nreads) begin
        n_err++;
        $display("FAIL random%0d signed: sorted=%b idx=%0d reads=%0d, expected %b/%0d/%0d",
                 it, obs_sorted[1], obs_idx[1], obs_reads[1], e1.srt, e1.idx, e1.nreads);
      end
    end
    lat = 1;
  endtask

  task automatic test_reset_mid_scan();
    bit reached = 1'b0;
    exp_t e0;
    mem[1022] = 32'd10; mem[1023] = 32'd20; mem[0] = 32'd30; mem[1] = 32'd40;
    lat = 7;
    @(negedge clock);
    descending = 1'b0; strict = 1'b0; base_addr = 10'd1022; length = 11'd4; go = 1'b1;
    rd_base[0] = rd_count[0];
    @(negedge clock);
    go = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (rd_count[0] - rd_base[0] >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!reached) begin
      n_err++;
      $display("FAIL mid_scan_reads: %0d reads issued, required 2", rd_count[0] - rd_base[0]);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({busy[0], busy[1], done[0], done[1], mem_rd[0], mem_rd[1]} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_mid_scan: busy=%b%b done=%b%b mem_rd=%b%b, required all 0",
               busy[0], busy[1], done[0], done[1], mem_rd[0], mem_rd[1]);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (15) @(negedge clock);
    n_vec++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || busy[1] !== 1'b0 || done[1] !== 1'b0) begin
      n_err++;
      $display("FAIL stale_valid_ignored: busy=%b%b done=%b%b, required idle", busy[0], busy[1], done[0], done[1]);
    end
    lat = 2;
    sb0.push_back('{1'b1, '0, 4});
    run_scan(1'b0, 1'b1, 10'd1022, 11'd4, 2, 1'b0);
    e0 = sb0.pop_front();
    n_vec++;
    if (obs_sorted[0] !== e0.srt || obs_idx[0] !== e0.idx || obs_reads[0] != e0.nreads) begin
      n_err++;
      $display("FAIL scan_after_reset: sorted=%b idx=%0d reads=%0d, expected %b/%0d/%0d",
               obs_sorted[0], obs_idx[0], obs_reads[0], e0.srt, e0.idx, e0.nreads);
    end
    lat = 1;
  endtask

`ifdef SORT_CHECK_COUNT_EN
  task automatic test_count();
    exp_t e0;
    mem[300] = 32'd4; mem[301] = 32'd3; mem[302] = 32'd5; mem[303] = 32'd1; mem[304] = 32'd6;
    sb0.push_back('{1'b0, 10'd1, 5});
    run_scan(1'b0, 1'b0, 10'd300, 11'd5, 2, 1'b0);
    e0 = sb0.pop_front();
    n_vec++;
    if (obs_sorted[0] !== e0.srt || obs_idx[0] !== e0.idx || obs_reads[0] != e0.nreads || inv_count[0] !== 11'd2) begin
      n_err++;
      $display("FAIL count_scan: sorted=%b idx=%0d reads=%0d count=%0d, expected %b/%0d/%0d/2",
               obs_sorted[0], obs_idx[0], obs_reads[0], inv_count[0], e0.srt, e0.idx, e0.nreads);
    end
    @(negedge clock);
    go = 1'b1;
    repeat (2) @(negedge clock);
    n_vec++;
    if (inv_count[0] !== '0 || inv_count[1] !== '0 || busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL count_cleared_at_arm: count=%0d/%0d busy=%b, required 0/0/1", inv_count[0], inv_count[1], busy[0]);
    end
    go = 1'b0;
    repeat (40) @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_order_modes();
    test_short_and_hold();
    test_wrap_latency();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
`ifdef SORT_CHECK_COUNT_EN
    test_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
